onbellek_etiket_denetleyici: RTL and testbench

Parametrised N-way set-associative cache metadata controller: holds per-set tag, valid, dirty and tree pseudo-LRU state in flops, and answers lookup/fill/dirty/invalidate requests for the L1 data cache. It also runs a hardware flush sweep that streams dirty victims out through a write-back handshake. It generalises the fixed 2-way valid/dirty/LRU packing used beside the core to 2/4/8 ways with configurable set count and tag width. Data arrays stay in external RAM macros; this block only selects the way.

---
 rtl/onbellek_etiket_denetleyici.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_onbellek_etiket_denetleyici.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onbellek_etiket_denetleyici.sv
// Set-associative cache metadata controller: per-set tag/valid/dirty and
// tree pseudo-LRU state, request handling, and a flush sweep that streams
// dirty lines out through a write-back handshake.
module onbellek_etiket_denetleyici #(
  parameter int unsigned WAYS     = 2,
  parameter int unsigned SET_BITS = 8,
  parameter int unsigned TAG_BITS = 9
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [SET_BITS-1:0]       req_set_i,
  input  logic [TAG_BITS-1:0]       req_tag_i,
  input  logic [$clog2(WAYS)-1:0]   req_way_i,
  output logic                      rsp_valid_o,
  output logic                      rsp_hit_o,
  output logic [$clog2(WAYS)-1:0]   rsp_way_o,
  output logic [$clog2(WAYS)-1:0]   rsp_victim_way_o,
  output logic                      rsp_victim_valid_o,
  output logic                      rsp_victim_dirty_o,
  output logic [TAG_BITS-1:0]       rsp_victim_tag_o,
  input  logic                      flush_i,
  output logic                      flush_busy_o,
  output logic                      flush_done_o,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [SET_BITS-1:0]       wb_set_o,
  output logic [$clog2(WAYS)-1:0]   wb_way_o,
  output logic [TAG_BITS-1:0]       wb_tag_o
);

  localparam int unsigned WB    = $clog2(WAYS);
  localparam int unsigned SETS  = 2 ** SET_BITS;
  localparam int unsigned PW    = WAYS - 1;
  localparam int unsigned IDX_W = SET_BITS + WB;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_DIRTY  = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WB, ST_DONE} state_e;

  state_e state_q, state_d;

  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [PW-1:0]       plru_q  [SETS];

  logic [IDX_W-1:0]    idx_q;

  logic                rsp_valid_q, rsp_hit_q, rsp_vvalid_q, rsp_vdirty_q;
  logic [WB-1:0]       rsp_way_q, rsp_vway_q;
  logic [TAG_BITS-1:0] rsp_vtag_q;
  logic                flush_busy_q, flush_done_q;
  logic                wb_valid_q;
  logic [SET_BITS-1:0] wb_set_q;
  logic [WB-1:0]       wb_way_q;
  logic [TAG_BITS-1:0] wb_tag_q;

  logic                req_fire_c;
  logic [WAYS-1:0]     set_valid_c, set_dirty_c;
  logic [PW-1:0]       set_plru_c;
  logic                hit_c;
  logic [WB-1:0]       hit_way_c;
  logic                inv_any_c;
  logic [WB-1:0]       inv_way_c;
  logic [WB-1:0]       vict_way_c;
  logic                vict_valid_c, vict_dirty_c;
  logic [TAG_BITS-1:0] vict_tag_c;
  logic                touch_en_c;
  logic [WB-1:0]       touch_way_c;
  logic [PW-1:0]       plru_next_c;
  logic [SET_BITS-1:0] fl_set_c;
  logic [WB-1:0]       fl_way_c;
  logic                fl_dirty_line_c;
  logic                idx_last_c;
  logic                ent_clear_c;
  logic                wb_load_c;

  // Walk the heap-ordered tree from the root; a 0 node bit points to the lower half.
  function automatic logic [WB-1:0] plru_victim(input logic [PW-1:0] bits);
    int unsigned   node;
    logic [WB-1:0] way;
    node = 0;
    way  = '0;
    for (int l = 0; l < int'(WB); l++) begin
      way[int'(WB) - 1 - l] = bits[node];
      node = 2 * node + 1 + 32'(bits[node]);
    end
    return way;
  endfunction

  // Point every node on the path away from the touched way.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits,
                                               input logic [WB-1:0] way);
    int unsigned   node;
    logic [PW-1:0] res;
    node = 0;
    res  = bits;
    for (int l = 0; l < int'(WB); l++) begin
      res[node] = ~way[int'(WB) - 1 - l];
      node = 2 * node + 1 + 32'(way[int'(WB) - 1 - l]);
    end
    return res;
  endfunction

  assign req_ready_o = (state_q == ST_IDLE) && !flush_i && !rst_i;
  assign req_fire_c  = req_valid_i && req_ready_o;

  assign fl_set_c        = idx_q[IDX_W-1:WB];
  assign fl_way_c        = idx_q[WB-1:0];
  assign fl_dirty_line_c = valid_q[fl_set_c][fl_way_c] && dirty_q[fl_set_c][fl_way_c];
  assign idx_last_c      = (idx_q == {IDX_W{1'b1}});

  // Tag match, victim selection and PLRU update for the addressed set.
  always_comb begin
    set_valid_c  = valid_q[req_set_i];
    set_dirty_c  = dirty_q[req_set_i];
    set_plru_c   = plru_q[req_set_i];
    hit_c        = 1'b0;
    hit_way_c    = '0;
    inv_any_c    = 1'b0;
    inv_way_c    = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (set_valid_c[w] && (tag_q[req_set_i][w] == req_tag_i)) begin
        hit_c     = 1'b1;
        hit_way_c = WB'(w);
      end
      if (!set_valid_c[w]) begin
        inv_any_c = 1'b1;
        inv_way_c = WB'(w);
      end
    end
    vict_way_c   = inv_any_c ? inv_way_c : plru_victim(set_plru_c);
    vict_valid_c = set_valid_c[vict_way_c];
    vict_dirty_c = set_valid_c[vict_way_c] && set_dirty_c[vict_way_c];
    vict_tag_c   = tag_q[req_set_i][vict_way_c];

    touch_en_c  = 1'b0;
    touch_way_c = req_way_i;
    case (req_op_i)
      OP_LOOKUP: begin
        touch_en_c  = hit_c;
        touch_way_c = hit_way_c;
      end
      OP_FILL:  touch_en_c = 1'b1;
      OP_DIRTY: touch_en_c = set_valid_c[req_way_i];
      default:  touch_en_c = 1'b0;
    endcase
    plru_next_c = plru_touch(set_plru_c, touch_way_c);
  end

  // Flush sequencer next-state and per-cycle control.
  always_comb begin
    state_d     = state_q;
    ent_clear_c = 1'b0;
    wb_load_c   = 1'b0;
    case (state_q)
      ST_IDLE: if (flush_i) state_d = ST_SCAN;
      ST_SCAN: begin
        if (fl_dirty_line_c) begin
          state_d   = ST_WB;
          wb_load_c = 1'b1;
        end else begin
          ent_clear_c = 1'b1;
          if (idx_last_c) state_d = ST_DONE;
        end
      end
      ST_WB: begin
        if (wb_ready_i) begin
          ent_clear_c = 1'b1;
          state_d     = idx_last_c ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Sweep index, status strobes, write-back and lookup response registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      idx_q        <= '0;
      flush_busy_q <= 1'b0;
      flush_done_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_set_q     <= '0;
      wb_way_q     <= '0;
      wb_tag_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_vway_q   <= '0;
      rsp_vvalid_q <= 1'b0;
      rsp_vdirty_q <= 1'b0;
      rsp_vtag_q   <= '0;
    end else begin
      flush_busy_q <= (state_d == ST_SCAN) || (state_d == ST_WB);
      flush_done_q <= (state_d == ST_DONE);
      if (state_q == ST_IDLE)  idx_q <= '0;
      else if (ent_clear_c)    idx_q <= idx_q + IDX_W'(1);
      if (wb_load_c) begin
        wb_valid_q <= 1'b1;
        wb_set_q   <= fl_set_c;
        wb_way_q   <= fl_way_c;
        wb_tag_q   <= tag_q[fl_set_c][fl_way_c];
      end else if ((state_q == ST_WB) && wb_ready_i) begin
        wb_valid_q <= 1'b0;
      end
      rsp_valid_q <= req_fire_c && (req_op_i == OP_LOOKUP);
      if (req_fire_c && (req_op_i == OP_LOOKUP)) begin
        rsp_hit_q    <= hit_c;
        rsp_way_q    <= hit_way_c;
        rsp_vway_q   <= vict_way_c;
        rsp_vvalid_q <= vict_valid_c;
        rsp_vdirty_q <= vict_dirty_c;
        rsp_vtag_q   <= vict_tag_c;
      end
    end
  end

  // Valid, dirty and PLRU state: request updates, sweep clears, post-flush PLRU wipe.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (req_fire_c) begin
        case (req_op_i)
          OP_FILL: begin
            valid_q[req_set_i][req_way_i] <= 1'b1;
            dirty_q[req_set_i][req_way_i] <= 1'b0;
          end
          OP_DIRTY: begin
            if (set_valid_c[req_way_i]) dirty_q[req_set_i][req_way_i] <= 1'b1;
          end
          OP_INVAL: begin
            valid_q[req_set_i][req_way_i] <= 1'b0;
            dirty_q[req_set_i][req_way_i] <= 1'b0;
          end
          default: ;
        endcase
        if (touch_en_c) plru_q[req_set_i] <= plru_next_c;
      end
      if (ent_clear_c) begin
        valid_q[fl_set_c][fl_way_c] <= 1'b0;
        dirty_q[fl_set_c][fl_way_c] <= 1'b0;
      end
      if (state_q == ST_DONE) begin
        for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
      end
    end
  end

  // Tag storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (req_fire_c && (req_op_i == OP_FILL)) tag_q[req_set_i][req_way_i] <= req_tag_i;
  end

  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_hit_o          = rsp_hit_q;
  assign rsp_way_o          = rsp_way_q;
  assign rsp_victim_way_o   = rsp_vway_q;
  assign rsp_victim_valid_o = rsp_vvalid_q;
  assign rsp_victim_dirty_o = rsp_vdirty_q;
  assign rsp_victim_tag_o   = rsp_vtag_q;
  assign flush_busy_o       = flush_busy_q;
  assign flush_done_o       = flush_done_q;
  assign wb_valid_o         = wb_valid_q;
  assign wb_set_o           = wb_set_q;
  assign wb_way_o           = wb_way_q;
  assign wb_tag_o           = wb_tag_q;

endmodule

// File: tb/tb_onbellek_etiket_denetleyici.sv
// Scoreboard bench for the cache metadata controller, 4-way configuration.
module tb_onbellek_etiket_denetleyici;

  localparam int unsigned WAYS     = 4;
  localparam int unsigned SET_BITS = 4;
  localparam int unsigned TAG_BITS = 9;
  localparam int unsigned WB       = 2;
  localparam int unsigned SETS     = 16;
  localparam int unsigned N        = SETS * WAYS;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [1:0]          req_op_i = '0;
  logic [SET_BITS-1:0] req_set_i = '0;
  logic [TAG_BITS-1:0] req_tag_i = '0;
  logic [WB-1:0]       req_way_i = '0;
  logic                rsp_valid_o, rsp_hit_o;
  logic [WB-1:0]       rsp_way_o, rsp_victim_way_o;
  logic                rsp_victim_valid_o, rsp_victim_dirty_o;
  logic [TAG_BITS-1:0] rsp_victim_tag_o;
  logic                flush_i = 1'b0;
  logic                flush_busy_o, flush_done_o;
  logic                wb_valid_o;
  logic                wb_ready_i = 1'b0;
  logic [SET_BITS-1:0] wb_set_o;
  logic [WB-1:0]       wb_way_o;
  logic [TAG_BITS-1:0] wb_tag_o;

  onbellek_etiket_denetleyici #(
    .WAYS(WAYS), .SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_set_i(req_set_i), .req_tag_i(req_tag_i), .req_way_i(req_way_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_way_o(rsp_way_o),
    .rsp_victim_way_o(rsp_victim_way_o), .rsp_victim_valid_o(rsp_victim_valid_o),
    .rsp_victim_dirty_o(rsp_victim_dirty_o), .rsp_victim_tag_o(rsp_victim_tag_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_set_o(wb_set_o), .wb_way_o(wb_way_o), .wb_tag_o(wb_tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int way;
    int vway;
    bit vvalid;
    bit vdirty;
    int vtag;
  } exp_t;

  typedef struct {
    int set;
    int way;
    int tag;
  } wb_t;

  exp_t rsp_q[$];
  wb_t  wb_q[$];
  int   errors = 0;
  int   checks = 0;

  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  bit m_tree  [SETS][WAYS-1];

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < int'(SETS); s++) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      for (int n = 0; n < int'(WAYS) - 1; n++) m_tree[s][n] = 1'b0;
    end
  endfunction

  // Interval descent: recently used half gets the node pointing at the other half.
  function automatic void m_touch(input int s, input int w);
    int lo = 0;
    int hi = WAYS;
    int node = 0;
    int mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_tree[s][node] = 1'b1; node = 2 * node + 1; hi = mid; end
      else         begin m_tree[s][node] = 1'b0; node = 2 * node + 2; lo = mid; end
    end
  endfunction

  function automatic int m_victim(input int s);
    int lo = 0;
    int hi = WAYS;
    int node = 0;
    int mid;
    for (int w = 0; w < int'(WAYS); w++) if (!m_valid[s][w]) return w;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (!m_tree[s][node]) begin node = 2 * node + 1; hi = mid; end
      else                  begin node = 2 * node + 2; lo = mid; end
    end
    return lo;
  endfunction

  function automatic void m_accept(input int op, input int s, input int tag, input int w);
    exp_t e;
    case (op)
      0: begin
        e.hit = 1'b0;
        e.way = 0;
        for (int k = 0; k < int'(WAYS); k++)
          if (!e.hit && m_valid[s][k] && m_tag[s][k] == tag) begin e.hit = 1'b1; e.way = k; end
        e.vway   = m_victim(s);
        e.vvalid = m_valid[s][e.vway];
        e.vdirty = m_dirty[s][e.vway];
        e.vtag   = m_tag[s][e.vway];
        rsp_q.push_back(e);
        if (e.hit) m_touch(s, e.way);
      end
      1: begin
        m_tag[s][w] = tag; m_valid[s][w] = 1'b1; m_dirty[s][w] = 1'b0; m_touch(s, w);
      end
      2: if (m_valid[s][w]) begin m_dirty[s][w] = 1'b1; m_touch(s, w); end
      default: begin m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; end
    endcase
  endfunction

  function automatic int pick_tag(input int s, input int w);
    int t;
    bit dup;
    do begin
      t = 'h100 + $urandom_range(0, 7);
      dup = 1'b0;
      for (int k = 0; k < int'(WAYS); k++)
        if (k != w && m_valid[s][k] && m_tag[s][k] == t) dup = 1'b1;
    end while (dup);
    return t;
  endfunction

  // Response monitor: every strobe consumes the oldest predicted lookup result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && rsp_valid_o) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid_o), 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_hit", 64'(rsp_hit_o), 64'(e.hit));
        chk("rsp_way", 64'(rsp_way_o), 64'(e.way));
        chk("rsp_victim_way", 64'(rsp_victim_way_o), 64'(e.vway));
        chk("rsp_victim_valid", 64'(rsp_victim_valid_o), 64'(e.vvalid));
        chk("rsp_victim_dirty", 64'(rsp_victim_dirty_o), 64'(e.vdirty));
        if (e.vvalid) chk("rsp_victim_tag", 64'(rsp_victim_tag_o), 64'(e.vtag));
      end
    end
  end

  task automatic do_req(input int op, input int s, input int tag, input int w);
    req_valid_i = 1'b1;
    req_op_i    = 2'(op);
    req_set_i   = SET_BITS'(s);
    req_tag_i   = TAG_BITS'(tag);
    req_way_i   = WB'(w);
    @(negedge clk);
    chk("req_ready", 64'(req_ready_o), 1);
    if (req_ready_o) m_accept(op, s, tag, w);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; wb_ready_i = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", 64'(req_ready_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_reset();
    rsp_q.delete();
  endtask

  task automatic do_flush(input int st_lo, input int st_hi, input bit with_req);
    int cyc, exp_cyc, stall_left, hs, n_exp, slen;
    bit in_entry, done_seen;
    wb_t cur;
    wb_q.delete();
    for (int i = 0; i < int'(N); i++) begin
      int s = i / WAYS;
      int w = i % WAYS;
      if (m_valid[s][w] && m_dirty[s][w]) wb_q.push_back('{s, w, m_tag[s][w]});
    end
    n_exp = wb_q.size();
    flush_i = 1'b1;
    if (with_req) begin
      req_valid_i = 1'b1; req_op_i = 2'b00; req_set_i = SET_BITS'(1); req_tag_i = TAG_BITS'(5);
    end
    @(negedge clk);
    chk("ready_vs_flush", 64'(req_ready_o), 0);
    @(posedge clk); #1;
    flush_i = 1'b0; req_valid_i = 1'b0; wb_ready_i = 1'b0;
    cyc = 0; exp_cyc = N + 1; in_entry = 0; stall_left = 0; hs = 0; done_seen = 0;
    for (int k = 0; k < 5000 && !done_seen; k++) begin
      @(negedge clk);
      cyc++;
      if (flush_done_o) done_seen = 1'b1;
      else begin
        chk("flush_busy", 64'(flush_busy_o), 1);
        if (wb_valid_o) begin
          if (wb_q.size() == 0) chk("wb_unexpected", 64'(wb_valid_o), 0);
          else begin
            cur = wb_q[0];
            chk("wb_set", 64'(wb_set_o), 64'(cur.set));
            chk("wb_way", 64'(wb_way_o), 64'(cur.way));
            chk("wb_tag", 64'(wb_tag_o), 64'(cur.tag));
            if (!in_entry) begin
              in_entry = 1'b1;
              slen = $urandom_range(st_hi, st_lo);
              stall_left = slen - 1;
              exp_cyc += slen + 1;
            end else if (wb_ready_i) begin
              void'(wb_q.pop_front());
              in_entry = 1'b0;
              hs++;
            end else stall_left--;
          end
        end
        @(posedge clk); #1;
        wb_ready_i = in_entry && (stall_left == 0);
      end
    end
    chk("flush_done_seen", 64'(done_seen), 1);
    chk("flush_cycles", 64'(cyc), 64'(exp_cyc));
    chk("busy_in_done", 64'(flush_busy_o), 0);
    chk("wb_count", 64'(hs), 64'(n_exp));
    chk("wb_left", 64'(wb_q.size()), 0);
    wb_ready_i = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", 64'(flush_done_o), 0);
    chk("ready_after_flush", 64'(req_ready_o), 1);
    @(posedge clk); #1;
    m_reset();
  endtask

  task automatic rand_ops(input int count);
    int op, s, w, r;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 40) ? 0 : (r < 70) ? 1 : (r < 85) ? 2 : 3;
      s = $urandom_range(0, 3);
      w = $urandom_range(0, WAYS - 1);
      do_req(op, s, (op == 1) ? pick_tag(s, w) : 'h100 + $urandom_range(0, 8), w);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int pulses, wbv, seen;
    m_reset();
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAYS); w++) m_tag[s][w] = 0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_ready", 64'(req_ready_o), 1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
    chk("rst_busy", 64'(flush_busy_o), 0);
    chk("rst_done", 64'(flush_done_o), 0);
    chk("rst_wb_valid", 64'(wb_valid_o), 0);
    chk("rst_wb_tag", 64'(wb_tag_o), 0);
    chk("rst_rsp_vtag", 64'(rsp_victim_tag_o), 0);
    @(posedge clk); #1;

    do_req(0, 5, 'h1A3, 0);
    do_req(1, 5, 'h011, 0);
    do_req(1, 5, 'h022, 1);
    do_req(0, 5, 'h011, 0);
    do_req(0, 5, 'h022, 0);
    do_req(0, 5, 'h033, 0);
    for (int w = 0; w < int'(WAYS); w++) do_req(1, 0, 'h0A0 + w, w);
    do_req(0, 0, 'h0A0, 0);
    do_req(0, 0, 'h0A2, 0);
    do_req(0, 0, 'h0FF, 0);
    do_req(0, 5, 'h0FF, 0);
    do_req(2, 7, 0, 2);
    do_req(0, 7, 'h0FF, 0);
    do_req(1, 3, 'h044, 1);
    do_req(2, 3, 0, 1);
    do_req(0, 3, 'h055, 0);
    do_flush(5, 5, 1'b0);
    do_req(0, 3, 'h044, 0);
    do_req(0, 0, 'h0A1, 0);
    do_flush(1, 1, 1'b1);

    rand_ops(500);
    do_flush(1, 4, 1'b0);
    rand_ops(200);

    do_req(1, 2, 'h077, 3);
    do_req(2, 2, 0, 3);
    do_req(1, 9, 'h088, 0);
    do_req(2, 9, 0, 0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; wb_ready_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(negedge clk);
      if (wb_valid_o) seen = 1;
    end
    chk("wb_before_reset", 64'(seen), 1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("abort_wb_valid", 64'(wb_valid_o), 0);
    chk("abort_busy", 64'(flush_busy_o), 0);
    chk("abort_done", 64'(flush_done_o), 0);
    chk("abort_wb_set", 64'(wb_set_o), 0);
    pulses = 0; wbv = 0;
    for (int k = 0; k < int'(N) + 10; k++) begin
      @(negedge clk);
      if (flush_done_o) pulses++;
      if (wb_valid_o) wbv++;
    end
    chk("abort_no_done", 64'(pulses), 0);
    chk("abort_no_wb", 64'(wbv), 0);
    @(posedge clk); #1;
    do_req(0, 2, 'h077, 0);
    do_req(0, 9, 'h088, 0);
    do_req(0, 3, 'h044, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("rsp_pending", 64'(rsp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
